ysyx_23060236_icache_refill: RTL and testbench
==============================================

# ysyx_23060236_icache_refill

Instruction-fetch front end for the I-cache. Accepts fetch PCs from the IFU, looks them up in the I-cache array, and returns the instruction on a hit. On a miss, issues one AXI4 INCR burst for the 32-byte line, writes each beat into the array, then re-looks up. Also forwards fence.i and flushes the array after bus errors, so a partially written line is never left valid.

## Interface
- ADDR_LEN, 32, address width
- DATA_LEN, 32, data/beat width
- OFFSET_LEN, 5, line-offset bits (32-byte line, 8 words)

- clock  in  1  single clock, all state on posedge
- reset  in  1  synchronous, active-low (reset==0 resets on the clock edge)
- in_valid / in_ready  in/out  1  fetch-request handshake
- in_pc  in  ADDR_LEN  fetch address, bits[1:0] ignored
- out_valid / out_ready  out/in  1  response handshake
- out_inst  out  DATA_LEN  instruction
- out_pc  out  ADDR_LEN  PC of the response
- out_fault  out  1  access fault (bus error on refill)
- fence_i  in  1  fence.i pulse from the pipeline
- icache_araddr  out  ADDR_LEN  lookup address
- icache_rdata  in  DATA_LEN  array read data (combinational)
- icache_hit  in  1  array hit (combinational)
- icache_awaddr / icache_wdata / icache_wvalid  out  ADDR_LEN/DATA_LEN/1  array write port
- icache_fencei  out  1  array invalidate-all
- arvalid / arready  out/in  1  AXI read-address handshake
- araddr  out  ADDR_LEN;  arlen  out  8;  arsize  out  3;  arburst  out  2
- rvalid / rready  in/out  1  AXI read-data handshake
- rdata  in  DATA_LEN;  rresp  in  2;  rlast  in  1

## Operation
- States: IDLE, LOOKUP, AR, R, RESP.
- IDLE: in_ready=1. On in_valid: latch pc_r=in_pc and go to LOOKUP.
- LOOKUP: icache_araddr=pc_r.
  - icache_hit=1: latch inst_r=icache_rdata, fault_r=0, go to RESP.
  - Otherwise: go to AR.
- AR: arvalid=1, araddr={pc_r[31:5],5'b0}, arlen=7, arsize=2, arburst=2'b01. On arready, clear cnt and err_r, then go to R.
- R: rready=1. On each rvalid beat:
  - icache_wvalid=1, icache_awaddr={pc_r[31:5],cnt,2'b00}, icache_wdata=rdata.
  - cnt increments and wraps mod 8.
  - err_r |= (rresp!=0).
- Last beat is the beat with rlast=1. Let bad = err_r | (rresp!=0) | (cnt!=7).
  - bad: assert icache_fencei on this same cycle (array clear has priority over the write), fault_r=1, inst_r=0, go to RESP.
  - Otherwise: go to LOOKUP. The re-lookup now hits.
- RESP: out_valid=1, out_inst=inst_r, out_pc=pc_r, out_fault=fault_r. On out_ready, go to IDLE.
- icache_fencei = fence_i | last-beat error flush. fence_i is forwarded combinationally in every state.
- fence_i during LOOKUP: that cycle's hit uses the pre-clear array contents.
- fence_i during R: remaining beats still write and set valid. Memory data is current.
- icache_araddr=pc_r in all states. All other outputs are 0 when their state is not active.
- Reset (reset==0): state=IDLE, cnt=0, pc_r=inst_r=0, fault_r=err_r=0. Every handshake output is 0.
- Reset mid-burst abandons the transaction. Memory is reset together with this block.

## Timing
- Hit latency:
  - Request accepted at edge 0.
  - LOOKUP in cycle 1.
  - out_valid from cycle 2.
  - Peak throughput is one fetch per 3 cycles with out_ready=1.
- Miss latency: 3 + AR wait + 8 beats + 1 re-lookup cycle, then RESP.
- AXI: arvalid held until arready. araddr and the burst fields are stable while arvalid=1. rready is held for the whole R state.
- in_ready=0 outside IDLE. out_valid is held, with stable data, until out_ready.

## Test plan
- Cold miss, pc=0x8000_0014, memory word k=0x1000+k, no stalls:
  - AR araddr=0x8000_0000, arlen=7.
  - 8 array writes at 0x8000_0000..0x8000_001C.
  - Response out_inst=0x1005, out_pc=0x8000_0014, out_fault=0.
- Hit after refill, pc=0x8000_0018: out_valid exactly 2 cycles after acceptance, out_inst=0x1006, no AR issued.
- Bus error, rresp=2'b10 on beat 3:
  - All 8 beats are consumed.
  - icache_fencei=1 on the rlast cycle.
  - Response out_fault=1, out_inst=0.
  - Refetching the same pc misses again.
- Early rlast on beat 5 (cnt=5): treated as a fault, with the array flushed as above.
- Backpressure: arready delayed 4 cycles, rvalid gapped every other cycle, out_ready low for 3 cycles. Address, data and response stay stable; result is identical to the no-stall case.
- fence_i pulse while in R, then reset=0 asserted in the middle of a second burst:
  - Refill completes.
  - After reset: state is IDLE, all valids are 0, in_ready=1 on the next cycle.

Source files
------------

// File: rtl/ysyx_23060236_icache_refill_if.sv
// ---------------------------------------------------------------------------
// ysyx_23060236_icache_refill_if
// Bundles every handshake/bus signal of the I-cache refill front end:
//   - IFU fetch request  : in_valid/in_ready/in_pc
//   - IFU response       : out_valid/out_ready/out_inst/out_pc/out_fault
//   - pipeline fence.i   : fence_i
//   - I-cache array port : icache_araddr/rdata/hit, awaddr/wdata/wvalid, fencei
//   - AXI4 read channel  : ar* / r*
// Modport master is the refill block's view, slave is the environment's view
// (IFU, array and AXI memory together).
// ---------------------------------------------------------------------------
interface ysyx_23060236_icache_refill_if #(
    parameter int ADDR_LEN = 32,
    parameter int DATA_LEN = 32
);
    logic                in_valid;
    logic                in_ready;
    logic [ADDR_LEN-1:0] in_pc;

    logic                out_valid;
    logic                out_ready;
    logic [DATA_LEN-1:0] out_inst;
    logic [ADDR_LEN-1:0] out_pc;
    logic                out_fault;

    logic                fence_i;

    logic [ADDR_LEN-1:0] icache_araddr;
    logic [DATA_LEN-1:0] icache_rdata;
    logic                icache_hit;
    logic [ADDR_LEN-1:0] icache_awaddr;
    logic [DATA_LEN-1:0] icache_wdata;
    logic                icache_wvalid;
    logic                icache_fencei;

    logic                arvalid;
    logic                arready;
    logic [ADDR_LEN-1:0] araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;

    logic                rvalid;
    logic                rready;
    logic [DATA_LEN-1:0] rdata;
    logic [1:0]          rresp;
    logic                rlast;

    modport master (
        input  in_valid, in_pc, out_ready, fence_i,
        input  icache_rdata, icache_hit,
        input  arready, rvalid, rdata, rresp, rlast,
        output in_ready, out_valid, out_inst, out_pc, out_fault,
        output icache_araddr, icache_awaddr, icache_wdata, icache_wvalid, icache_fencei,
        output arvalid, araddr, arlen, arsize, arburst, rready
    );

    modport slave (
        output in_valid, in_pc, out_ready, fence_i,
        output icache_rdata, icache_hit,
        output arready, rvalid, rdata, rresp, rlast,
        input  in_ready, out_valid, out_inst, out_pc, out_fault,
        input  icache_araddr, icache_awaddr, icache_wdata, icache_wvalid, icache_fencei,
        input  arvalid, araddr, arlen, arsize, arburst, rready
    );
endinterface

// File: rtl/ysyx_23060236_icache_refill.sv
// ---------------------------------------------------------------------------
// ysyx_23060236_icache_refill
// Instruction-fetch front end for the I-cache. A fetch PC is looked up in the
// external array; a hit is returned directly, a miss triggers one AXI4 INCR
// burst for the whole line, each beat is written into the array, and the PC
// is looked up again. A refill that ends badly (error response on any beat,
// or rlast on the wrong beat) clears the whole array on the last beat so a
// half-written line can never hit, and returns an access fault instead.
//
// Ports:
//   clock  : single clock, all state on posedge
//   reset  : synchronous, active-low
//   bus    : ysyx_23060236_icache_refill_if.master (IFU, array, AXI signals)
// ---------------------------------------------------------------------------
module ysyx_23060236_icache_refill #(
    parameter int ADDR_LEN   = 32,
    parameter int DATA_LEN   = 32,
    parameter int OFFSET_LEN = 5
) (
    input  logic clock,
    input  logic reset,
    ysyx_23060236_icache_refill_if.master bus
);

    localparam int CNT_W = OFFSET_LEN - 2;              // word index within a line
    localparam int WORDS = 1 << CNT_W;
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(WORDS - 1);
    localparam logic [7:0]       BURST_LEN = 8'(WORDS - 1);
    localparam logic [2:0]       BEAT_SIZE = 3'($clog2(DATA_LEN / 8));

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_AR,
        S_R,
        S_RESP
    } state_e;

    state_e              state_q;
    logic [ADDR_LEN-1:0] pc_q;
    logic [DATA_LEN-1:0] inst_q;
    logic                fault_q;
    logic                err_q;
    logic [CNT_W-1:0]    cnt_q;

    logic                run;
    logic                beat_fire;
    logic                beat_err;
    logic                last_bad;
    logic [ADDR_LEN-1:0] line_base;

    // Handshake outputs are forced low while reset is held, so the block is
    // silent on the bus even before the first reset edge has been seen.
    assign run       = reset;
    assign line_base = {pc_q[ADDR_LEN-1:OFFSET_LEN], {OFFSET_LEN{1'b0}}};
    assign beat_fire = (state_q == S_R) && bus.rvalid;
    assign beat_err  = (bus.rresp != 2'b00);
    // The burst is bad if any beat errored (including this one) or if rlast
    // did not land on the final word of the line.
    assign last_bad  = beat_fire && bus.rlast && (err_q || beat_err || (cnt_q != LAST_CNT));

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            inst_q  <= '0;
            fault_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        pc_q    <= bus.in_pc;
                        state_q <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    // After a good refill this lookup hits on the new line.
                    if (bus.icache_hit) begin
                        inst_q  <= bus.icache_rdata;
                        fault_q <= 1'b0;
                        state_q <= S_RESP;
                    end else begin
                        state_q <= S_AR;
                    end
                end
                S_AR: begin
                    if (bus.arready) begin
                        cnt_q   <= '0;
                        err_q   <= 1'b0;
                        state_q <= S_R;
                    end
                end
                S_R: begin
                    if (beat_fire) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        err_q <= err_q | beat_err;
                        if (bus.rlast) begin
                            if (last_bad) begin
                                fault_q <= 1'b1;
                                inst_q  <= '0;
                                state_q <= S_RESP;
                            end else begin
                                state_q <= S_LOOKUP;
                            end
                        end
                    end
                end
                S_RESP: begin
                    if (bus.out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // IFU side
    assign bus.in_ready  = run && (state_q == S_IDLE);
    assign bus.out_valid = run && (state_q == S_RESP);
    assign bus.out_inst  = (state_q == S_RESP) ? inst_q : '0;
    assign bus.out_pc    = (state_q == S_RESP) ? pc_q : '0;
    assign bus.out_fault = (state_q == S_RESP) && fault_q;

    // Array side: lookup address always tracks the latched PC.
    assign bus.icache_araddr = pc_q;
    assign bus.icache_wvalid = run && beat_fire;
    assign bus.icache_awaddr = beat_fire ? {pc_q[ADDR_LEN-1:OFFSET_LEN], cnt_q, 2'b00} : '0;
    assign bus.icache_wdata  = beat_fire ? bus.rdata : '0;
    // The array gives invalidate-all priority over a same-cycle write, so a
    // bad last beat leaves nothing of the line valid.
    assign bus.icache_fencei = bus.fence_i || (run && last_bad);

    // AXI read channel: fields are constant for the whole AR state.
    assign bus.arvalid = run && (state_q == S_AR);
    assign bus.araddr  = (state_q == S_AR) ? line_base : '0;
    assign bus.arlen   = (state_q == S_AR) ? BURST_LEN : '0;
    assign bus.arsize  = (state_q == S_AR) ? BEAT_SIZE : '0;
    assign bus.arburst = (state_q == S_AR) ? 2'b01 : 2'b00;
    assign bus.rready  = run && (state_q == S_R);

endmodule

// File: tb/tb_ysyx_23060236_icache_refill.sv
// ---------------------------------------------------------------------------
// tb_ysyx_23060236_icache_refill
// Environment: IFU driver, behavioural I-cache array, AXI memory slave with
// configurable stalls/errors, and a scoreboard monitor. The reference model
// tracks which lines should be cached and predicts each fetch's response.
// ---------------------------------------------------------------------------
module tb_ysyx_23060236_icache_refill;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    ysyx_23060236_icache_refill_if bus ();

    ysyx_23060236_icache_refill dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
        bit          hit;
        int          acc;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] ar_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic [31:0] mem [0:1023];     // backing memory for 0x8000_0000..0x8000_0FFF
    bit          ref_valid [0:127];

    // per-request environment configuration
    int cfg_ar_delay  = 0;
    bit cfg_gap       = 0;
    int cfg_err_beat  = -1;
    int cfg_last_beat = 7;
    bit cfg_fence     = 0;
    int cfg_out_stall = 0;
    int sl_beat       = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- behavioural I-cache array ----------------
    logic [31:0] arr_data [0:1023];
    bit          arr_valid [0:127];

    always_comb begin
        bus.icache_hit   = 1'b0;
        bus.icache_rdata = arr_data[bus.icache_araddr[11:2]];
        if (bus.icache_araddr[31:12] == 20'h80000)
            bus.icache_hit = arr_valid[bus.icache_araddr[11:5]];
    end

    always @(posedge clock) begin
        if (!reset || bus.icache_fencei) begin
            for (int i = 0; i < 128; i++) arr_valid[i] <= 1'b0;
        end else if (bus.icache_wvalid && bus.icache_awaddr[31:12] == 20'h80000) begin
            arr_data[bus.icache_awaddr[11:2]]  <= bus.icache_wdata;
            arr_valid[bus.icache_awaddr[11:5]] <= 1'b1;
        end
    end

    // ---------------- AXI memory slave ----------------
    initial begin : axi_slave
        int phase, arw;
        bit gap_t;
        logic [31:0] sl_base;
        phase = 0; arw = 0; gap_t = 0; sl_base = '0;
        bus.arready = 0; bus.rvalid = 0; bus.rdata = '0; bus.rresp = '0;
        bus.rlast = 0; bus.fence_i = 0;
        forever begin
            @(posedge clock); #1;
            if (!reset) begin
                phase = 0; arw = 0; sl_beat = 0;
                bus.arready = 0; bus.rvalid = 0; bus.rlast = 0; bus.rresp = '0; bus.fence_i = 0;
                continue;
            end
            bus.fence_i = 0;
            if (phase == 0) begin
                if (bus.arready) begin
                    bus.arready = 0; phase = 2; sl_beat = 0; gap_t = 0; arw = 0;
                end else if (bus.arvalid) begin
                    if (arw >= cfg_ar_delay) begin
                        bus.arready = 1; sl_base = bus.araddr;
                    end else arw++;
                end else arw = 0;
            end else if (bus.rvalid) begin
                if (bus.rlast) begin
                    phase = 0; bus.rvalid = 0; bus.rlast = 0; bus.rresp = '0;
                end
                sl_beat++;
            end
            if (phase == 2) begin
                if (cfg_gap && gap_t) begin
                    bus.rvalid = 0;
                end else begin
                    bus.rvalid = 1;
                    bus.rdata  = mem[sl_base[11:2] + 10'(sl_beat)];
                    bus.rresp  = (sl_beat == cfg_err_beat) ? 2'b10 : 2'b00;
                    bus.rlast  = (sl_beat == cfg_last_beat);
                end
                if (cfg_gap) gap_t = !gap_t;
                if (cfg_fence && sl_beat == 2 && !bus.rvalid) bus.fence_i = 1;
            end
        end
    end

    // ---------------- response backpressure ----------------
    initial begin : out_ready_drv
        int sc;
        sc = 0; bus.out_ready = 0;
        forever begin
            @(posedge clock); #1;
            if (!bus.out_valid) begin bus.out_ready = 0; sc = 0; end
            else if (sc < cfg_out_stall) begin bus.out_ready = 0; sc++; end
            else bus.out_ready = 1;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        bit ov_last, ov_hold, ar_hold, bad;
        logic [31:0] p_inst, p_pc, p_araddr, wbase, eaddr;
        logic p_fault;
        int wcnt;
        exp_t e;
        ov_last = 0; ov_hold = 0; ar_hold = 0; wcnt = 0; wbase = '0;
        p_inst = '0; p_pc = '0; p_araddr = '0; p_fault = 0;
        forever begin
            @(negedge clock);
            if (!reset) begin ov_last = 0; ov_hold = 0; ar_hold = 0; wcnt = 0; continue; end
            if (ov_hold) begin
                chk("out_valid_held", bus.out_valid, 1);
                chk("out_inst_stable", bus.out_inst, p_inst);
                chk("out_pc_stable", bus.out_pc, p_pc);
                chk("out_fault_stable", bus.out_fault, p_fault);
            end
            if (bus.out_valid && !ov_last && sb_q.size() > 0 && sb_q[0].hit)
                chk("hit_latency", cyc - sb_q[0].acc, 2);
            if (bus.out_valid && bus.out_ready) begin
                chk("resp_expected", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    chk("out_pc", bus.out_pc, e.pc);
                    chk("out_inst", bus.out_inst, e.inst);
                    chk("out_fault", bus.out_fault, e.fault);
                    $display("resp pc=0x%08h inst=0x%08h fault=%0b hit=%0b", bus.out_pc, bus.out_inst, bus.out_fault, e.hit);
                end
            end
            ov_last = bus.out_valid;
            ov_hold = bus.out_valid && !bus.out_ready;
            p_inst = bus.out_inst; p_pc = bus.out_pc; p_fault = bus.out_fault;

            if (ar_hold) begin
                chk("arvalid_held", bus.arvalid, 1);
                chk("araddr_stable", bus.araddr, p_araddr);
            end
            if (bus.arvalid && bus.arready) begin
                chk("ar_expected", ar_q.size() != 0, 1);
                wbase = bus.araddr;
                if (ar_q.size() != 0) begin
                    wbase = ar_q.pop_front();
                    chk("araddr", bus.araddr, wbase);
                end
                chk("arlen", bus.arlen, 7);
                chk("arsize", bus.arsize, 2);
                chk("arburst", bus.arburst, 1);
                wcnt = 0;
            end
            ar_hold = bus.arvalid && !bus.arready;
            p_araddr = bus.araddr;

            if (bus.rvalid) chk("rready_in_burst", bus.rready, 1);
            if (bus.icache_wvalid) begin
                eaddr = wbase + 32'(wcnt * 4);
                chk("icache_awaddr", bus.icache_awaddr, eaddr);
                chk("icache_wdata", bus.icache_wdata, mem[eaddr[11:2]]);
                wcnt++;
            end
            bad = (cfg_err_beat >= 0 && cfg_err_beat <= cfg_last_beat) || (cfg_last_beat != 7);
            chk("icache_fencei", bus.icache_fencei,
                bus.fence_i | (bus.rvalid & bus.rready & bus.rlast & bad));
        end
    end

    // ---------------- driver + reference model ----------------
    task automatic set_cfg(input int ard, input bit gap, input int errb, input int lastb,
                           input bit fen, input int stall);
        cfg_ar_delay = ard; cfg_gap = gap; cfg_err_beat = errb;
        cfg_last_beat = lastb; cfg_fence = fen; cfg_out_stall = stall;
    endtask

    task automatic clear_ref();
        for (int i = 0; i < 128; i++) ref_valid[i] = 0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 3000) begin @(negedge clock); n++; end
        chk("resp_timeout", sb_q.size(), 0);
        chk("ar_outstanding", ar_q.size(), 0);
        sb_q.delete(); ar_q.delete();
        @(posedge clock); #1;
    endtask

    task automatic fetch(input logic [31:0] pc, input bit want_resp);
        exp_t e;
        int line;
        bit bad, got;
        line = int'(pc[11:5]);
        bad  = (cfg_err_beat >= 0 && cfg_err_beat <= cfg_last_beat) || (cfg_last_beat != 7);
        e.pc = pc; e.hit = ref_valid[line]; e.acc = 0;
        if (e.hit) begin
            e.inst = mem[pc[11:2]]; e.fault = 0;
        end else begin
            ar_q.push_back({pc[31:5], 5'b0});
            if (cfg_fence) clear_ref();
            if (bad) begin
                clear_ref(); e.inst = '0; e.fault = 1;
            end else begin
                ref_valid[line] = 1; e.inst = mem[pc[11:2]]; e.fault = 0;
            end
        end
        @(posedge clock); #1;
        bus.in_valid = 1; bus.in_pc = pc;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clock);
            if (bus.in_ready) begin got = 1; e.acc = cyc; end
        end
        chk("in_accept", got, 1);
        @(posedge clock); #1;
        bus.in_valid = 0;
        if (want_resp && got) sb_q.push_back(e);
        if (want_resp) wait_idle();
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_in_ready"}, bus.in_ready, 0);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_arvalid"}, bus.arvalid, 0);
        chk({tag, "_rready"}, bus.rready, 0);
        chk({tag, "_wvalid"}, bus.icache_wvalid, 0);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n, r;
        logic [31:0] pc;
        bus.in_valid = 0; bus.in_pc = '0;
        for (int i = 0; i < 1024; i++) mem[i] = (i < 64) ? 32'h1000 + 32'(i) : $urandom;
        clear_ref();

        reset = 0;
        repeat (3) begin @(negedge clock); check_quiet("reset"); end
        @(posedge clock); #1; reset = 1;
        @(negedge clock); chk("post_reset_in_ready", bus.in_ready, 1);

        set_cfg(0, 0, -1, 7, 0, 0);
        fetch(32'h8000_0014, 1);                     // cold miss -> 0x1005
        fetch(32'h8000_0018, 1);                     // hit -> 0x1006
        set_cfg(0, 0, 3, 7, 0, 0);
        fetch(32'h8000_0040, 1);                     // bus error on beat 3
        set_cfg(0, 0, -1, 7, 0, 0);
        fetch(32'h8000_0040, 1);                     // misses again
        set_cfg(0, 0, -1, 5, 0, 0);
        fetch(32'h8000_0060, 1);                     // early rlast
        set_cfg(4, 1, -1, 7, 0, 3);
        fetch(32'h8000_0084, 1);                     // backpressure everywhere
        fetch(32'h8000_0088, 1);                     // hit under response stall

        for (int k = 0; k < 30; k++) begin
            r = $urandom_range(0, 9);
            set_cfg($urandom_range(0, 3), 1'($urandom_range(0, 1)),
                    (r == 0) ? $urandom_range(0, 7) : -1,
                    (r == 1) ? $urandom_range(0, 6) : 7, 0, $urandom_range(0, 2));
            pc = 32'h8000_0000 + 32'($urandom_range(0, 127)) * 4;
            fetch(pc, 1);
        end

        set_cfg(0, 1, -1, 7, 1, 0);
        fetch(32'h8000_0200, 1);                     // fence.i during refill
        set_cfg(0, 0, -1, 7, 0, 0);
        fetch(32'h8000_0204, 1);                     // same line still cached

        set_cfg(1, 1, -1, 7, 0, 0);
        fetch(32'h8000_0300, 0);                     // burst to be abandoned
        n = 0;
        while (sl_beat < 3 && n < 200) begin @(negedge clock); n++; end
        chk("burst_reached_beat3", sl_beat >= 3, 1);
        @(posedge clock); #1; reset = 0;
        repeat (2) begin @(negedge clock); check_quiet("midreset"); end
        @(posedge clock); #1; reset = 1;
        sb_q.delete(); ar_q.delete(); clear_ref();
        @(negedge clock); chk("midreset_in_ready", bus.in_ready, 1);
        set_cfg(0, 0, -1, 7, 0, 0);
        fetch(32'h8000_0300, 1);                     // clean miss after reset

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
